// File: rtl/add_lane_scheduler_pkg.sv
// Shared types and constants for the add-lane scheduler.
// Lane/mode encodings and the registered result bundle.
package add_sched_pkg;

  localparam int LANE_LO = 0;
  localparam int LANE_HI = 1;

  localparam logic MODE_32 = 1'b1;
  localparam logic MODE_16 = 1'b0;

  // Fixed field widths: up to 8 requesters, tags up to 16 bits.
  localparam int SRC_W    = 3;
  localparam int ID_MAX_W = 16;

  typedef struct packed {
    logic                wide;
    logic                lo_vld;
    logic                hi_vld;
    logic [SRC_W-1:0]    lo_src;
    logic [SRC_W-1:0]    hi_src;
    logic [ID_MAX_W-1:0] lo_id;
    logic [ID_MAX_W-1:0] hi_id;
    logic [31:0]         sum;
    logic                cout;
  } res_t;

endpackage

// File: rtl/add_lane_scheduler_if.sv
// Request/result bundle of the add-lane scheduler.
// slave: scheduler side; master: requesters + consumer.
interface add_lane_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 4
);
  localparam int SW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_wide;
  logic [NUM_REQ*32-1:0]   req_x;
  logic [NUM_REQ*32-1:0]   req_y;
  logic [NUM_REQ*ID_W-1:0] req_id;
  logic [NUM_REQ-1:0]      req_ready;

  logic            res_valid;
  logic            res_ready;
  logic            res_wide;
  logic            res_lo_vld;
  logic            res_hi_vld;
  logic [SW-1:0]   res_lo_src;
  logic [SW-1:0]   res_hi_src;
  logic [ID_W-1:0] res_lo_id;
  logic [ID_W-1:0] res_hi_id;
  logic [31:0]     res_sum;
  logic            res_cout;

  modport master (
    output req_valid, req_wide, req_x, req_y, req_id,
    output res_ready,
    input  req_ready,
    input  res_valid, res_wide, res_lo_vld, res_hi_vld,
    input  res_lo_src, res_hi_src, res_lo_id, res_hi_id,
    input  res_sum, res_cout
  );

  modport slave (
    input  req_valid, req_wide, req_x, req_y, req_id,
    input  res_ready,
    output req_ready,
    output res_valid, res_wide, res_lo_vld, res_hi_vld,
    output res_lo_src, res_hi_src, res_lo_id, res_hi_id,
    output res_sum, res_cout
  );

endinterface

// File: rtl/add_lane_scheduler_adder.sv
// Mode-configurable adder: one 32-bit add or two 16-bit lanes.
// Ports: mode_i, x_i, y_i, cin_i in; s_o, cout_o out.
module Adder (
  input  logic        mode_i,
  input  logic [31:0] x_i,
  input  logic [31:0] y_i,
  input  logic        cin_i,
  output logic [31:0] s_o,
  output logic        cout_o
);

  logic [32:0] w;
  logic [15:0] lo;
  logic [16:0] hi;

  // In 16-bit mode the lo carry is dropped, never fed into hi.
  always_comb begin
    w  = {1'b0, x_i} + {1'b0, y_i} + 33'(cin_i);
    lo = x_i[15:0] + y_i[15:0] + 16'(cin_i);
    hi = {1'b0, x_i[31:16]} + {1'b0, y_i[31:16]};
    if (mode_i) begin
      s_o    = w[31:0];
      cout_o = w[32];
    end else begin
      s_o    = {hi[15:0], lo};
      cout_o = hi[16];
    end
  end

endmodule

// File: rtl/add_lane_scheduler_rr_pick.sv
// Cyclic find-first-set of mask_i starting at start_i.
// Ports: mask_i, start_i in; found_o, idx_o out.
module rr_pick #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  mask_i,
  input  logic [IW-1:0] start_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);

  int j;

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    j       = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(start_i) + k) % N;
      if (!found_o && mask_i[j]) begin
        found_o = 1'b1;
        idx_o   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/add_lane_scheduler.sv
// Shares one adder among NUM_REQ requesters; pairs narrow adds
// when ADD_SCHED_PACK_EN is defined. Ports: clk, rst_n, bus (slave).
import add_sched_pkg::*;

module add_lane_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 4
) (
  input  logic clk,
  input  logic rst_n,
  add_lane_scheduler_if.slave bus
);

  localparam int IW = $clog2(NUM_REQ);

  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      a_idx, b_idx, b_start, last;
  logic               a_fnd, b_fnd, a_wide, pair, issue;
  logic [NUM_REQ-1:0] b_mask, rdy;
  logic [31:0]        xa, ya, op_x, op_y, sum;
  logic               mode, cout;
  logic               vld_q, vld_d;
  res_t               res_q, res_d;

  function automatic logic [IW-1:0] inc(
    input logic [IW-1:0] i
  );
    return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
  endfunction

  rr_pick #(.N(NUM_REQ)) u_pick_a (
    .mask_i  (bus.req_valid),
    .start_i (ptr_q),
    .found_o (a_fnd),
    .idx_o   (a_idx)
  );

  assign b_start = inc(a_idx);

`ifdef ADD_SCHED_PACK_EN
  assign b_mask = bus.req_valid & ~bus.req_wide
                & ~(NUM_REQ'(1) << a_idx);
`else
  assign b_mask = '0;
`endif

  rr_pick #(.N(NUM_REQ)) u_pick_b (
    .mask_i  (b_mask),
    .start_i (b_start),
    .found_o (b_fnd),
    .idx_o   (b_idx)
  );

  assign issue  = rst_n & a_fnd & (~vld_q | bus.res_ready);
  assign a_wide = bus.req_wide[a_idx];
  assign pair   = ~a_wide & b_fnd;
  assign xa     = bus.req_x[32*int'(a_idx) +: 32];
  assign ya     = bus.req_y[32*int'(a_idx) +: 32];

  always_comb begin
    mode = MODE_16;
    op_x = '0;
    op_y = '0;
    if (a_wide) begin
      mode = MODE_32;
      op_x = xa;
      op_y = ya;
    end else begin
      op_x[LANE_LO*16 +: 16] = xa[15:0];
      op_y[LANE_LO*16 +: 16] = ya[15:0];
      if (pair) begin
        op_x[LANE_HI*16 +: 16] =
          bus.req_x[32*int'(b_idx) +: 16];
        op_y[LANE_HI*16 +: 16] =
          bus.req_y[32*int'(b_idx) +: 16];
      end
    end
  end

  Adder u_add (
    .mode_i (mode),
    .x_i    (op_x),
    .y_i    (op_y),
    .cin_i  (1'b0),
    .s_o    (sum),
    .cout_o (cout)
  );

  always_comb begin
    rdy = '0;
    if (issue) begin
      rdy[a_idx] = 1'b1;
      if (pair) rdy[b_idx] = 1'b1;
    end
  end

  assign bus.req_ready = rdy;

  assign last  = pair ? b_idx : a_idx;
  assign ptr_d = issue ? inc(last) : ptr_q;

  always_comb begin
    res_d = res_q;
    vld_d = vld_q;
    if (issue) begin
      vld_d        = 1'b1;
      res_d        = '0;
      res_d.wide   = a_wide;
      res_d.lo_vld = 1'b1;
      res_d.lo_src = SRC_W'(a_idx);
      res_d.lo_id  = ID_MAX_W'(
        bus.req_id[ID_W*int'(a_idx) +: ID_W]);
      res_d.sum    = sum;
      res_d.cout   = cout;
      if (pair) begin
        res_d.hi_vld = 1'b1;
        res_d.hi_src = SRC_W'(b_idx);
        res_d.hi_id  = ID_MAX_W'(
          bus.req_id[ID_W*int'(b_idx) +: ID_W]);
      end
    end else if (bus.res_ready) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      vld_q <= 1'b0;
      res_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      vld_q <= vld_d;
      res_q <= res_d;
    end
  end

  assign bus.res_valid  = vld_q;
  assign bus.res_wide   = res_q.wide;
  assign bus.res_lo_vld = res_q.lo_vld;
  assign bus.res_hi_vld = res_q.hi_vld;
  assign bus.res_lo_src = res_q.lo_src[IW-1:0];
  assign bus.res_hi_src = res_q.hi_src[IW-1:0];
  assign bus.res_lo_id  = res_q.lo_id[ID_W-1:0];
  assign bus.res_hi_id  = res_q.hi_id[ID_W-1:0];
  assign bus.res_sum    = res_q.sum;
  assign bus.res_cout   = res_q.cout;

  // Struct fields are wider than this configuration needs.
  logic unused_res;
  assign unused_res = ^{res_q.lo_src, res_q.hi_src,
                        res_q.lo_id, res_q.hi_id};

endmodule

// File: tb/tb_add_lane_scheduler.sv
// Directed self-checking bench for add_lane_scheduler.
// Expectations follow ADD_SCHED_PACK_EN when it is defined.
module tb_add_lane_scheduler;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  add_lane_scheduler_if #(.NUM_REQ(4), .ID_W(4)) bus();

  add_lane_scheduler #(.NUM_REQ(4), .ID_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h",
             tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic w,
                         input logic [31:0] x,
                         input logic [31:0] y,
                         input logic [3:0] id);
    bus.req_valid[i]      = 1'b1;
    bus.req_wide[i]       = w;
    bus.req_x[32*i +: 32] = x;
    bus.req_y[32*i +: 32] = y;
    bus.req_id[4*i +: 4]  = id;
  endtask

  task automatic drop(input int i);
    bus.req_valid[i] = 1'b0;
  endtask

  task automatic at_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_wide  = '0;
    bus.req_x     = '0;
    bus.req_y     = '0;
    bus.req_id    = '0;
    bus.res_ready = 1'b1;

    // 1: reset state, then wide overflow add
    set_req(0, 1'b1, 32'hFFFF_FFFF, 32'h1, 4'h5);
    #12;
    check("rst_ready", 32'(bus.req_ready), 32'h0);
    check("rst_valid", 32'(bus.res_valid), 32'h0);
    check("rst_sum", bus.res_sum, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("t1_ready", 32'(bus.req_ready), 32'h1);
    at_pos();
    drop(0);
    check("t1_valid", 32'(bus.res_valid), 32'h1);
    check("t1_sum", bus.res_sum, 32'h0);
    check("t1_cout", 32'(bus.res_cout), 32'h1);
    check("t1_wide", 32'(bus.res_wide), 32'h1);
    check("t1_src", 32'(bus.res_lo_src), 32'h0);
    check("t1_id", 32'(bus.res_lo_id), 32'h5);
    check("t1_hivld", 32'(bus.res_hi_vld), 32'h0);

    // 2: narrow requesters 1 and 3, ptr=1
    at_neg();
    set_req(1, 1'b0, 32'h0000_FFFF, 32'h1, 4'h1);
    set_req(3, 1'b0, 32'hABCD_1234, 32'h1, 4'h3);
    #1;
`ifdef ADD_SCHED_PACK_EN
    check("t2_ready", 32'(bus.req_ready), 32'hA);
    at_pos();
    drop(1);
    drop(3);
    check("t2_sum", bus.res_sum, 32'h1235_0000);
    check("t2_cout", 32'(bus.res_cout), 32'h0);
    check("t2_lo", 32'(bus.res_lo_src), 32'h1);
    check("t2_hi", 32'(bus.res_hi_src), 32'h3);
    check("t2_hivld", 32'(bus.res_hi_vld), 32'h1);
    check("t2_hiid", 32'(bus.res_hi_id), 32'h3);
    check("t2_wide", 32'(bus.res_wide), 32'h0);
`else
    check("t2_ready", 32'(bus.req_ready), 32'h2);
    at_pos();
    drop(1);
    check("t2_sum", bus.res_sum, 32'h0);
    check("t2_lo", 32'(bus.res_lo_src), 32'h1);
    check("t2_hivld", 32'(bus.res_hi_vld), 32'h0);
    check("t2_wide", 32'(bus.res_wide), 32'h0);
    at_neg();
    check("t2b_ready", 32'(bus.req_ready), 32'h8);
    at_pos();
    drop(3);
    check("t2b_sum", bus.res_sum, 32'h0000_1235);
    check("t2b_lo", 32'(bus.res_lo_src), 32'h3);
    check("t2b_hivld", 32'(bus.res_hi_vld), 32'h0);
`endif

    // 3: four wide requesters, round robin
    for (int i = 0; i < 4; i++)
      set_req(i, 1'b1, 32'(i), 32'h10, 4'(i));
    for (int k = 0; k < 8; k++) begin
      at_neg();
      check("t3_ready", 32'(bus.req_ready),
            32'h1 << (k % 4));
      at_pos();
      check("t3_valid", 32'(bus.res_valid), 32'h1);
      check("t3_src", 32'(bus.res_lo_src), 32'(k % 4));
      check("t3_sum", bus.res_sum, 32'h10 + 32'(k % 4));
    end

    // 4: backpressure holds everything
    @(negedge clk);
    bus.res_ready = 1'b0;
    #1;
    for (int r = 0; r < 3; r++) begin
      check("t4_ready", 32'(bus.req_ready), 32'h0);
      at_pos();
      check("t4_valid", 32'(bus.res_valid), 32'h1);
      check("t4_src", 32'(bus.res_lo_src), 32'h3);
      check("t4_sum", bus.res_sum, 32'h13);
      at_neg();
    end
    bus.res_ready = 1'b1;
    #1;
    check("t4_release", 32'(bus.req_ready), 32'h1);
    at_pos();
    check("t4_src2", 32'(bus.res_lo_src), 32'h0);
    check("t4_sum2", bus.res_sum, 32'h10);

    // 5: move ptr to 3, then wrap-around pairing
    at_neg();
    for (int i = 0; i < 4; i++) drop(i);
    set_req(2, 1'b1, 32'h7, 32'h7, 4'h2);
    #1;
    check("t5_pre", 32'(bus.req_ready), 32'h4);
    at_pos();
    drop(2);
    check("t5_presrc", 32'(bus.res_lo_src), 32'h2);
    at_neg();
    set_req(3, 1'b0, 32'h5, 32'h3, 4'h3);
    set_req(0, 1'b1, 32'h8000_0000, 32'h8000_0000, 4'h0);
    set_req(1, 1'b0, 32'h10, 32'h20, 4'h1);
    #1;
`ifdef ADD_SCHED_PACK_EN
    check("t5_ready", 32'(bus.req_ready), 32'hA);
    at_pos();
    drop(3);
    drop(1);
    check("t5_sum", bus.res_sum, 32'h0030_0008);
    check("t5_lo", 32'(bus.res_lo_src), 32'h3);
    check("t5_hi", 32'(bus.res_hi_src), 32'h1);
    check("t5_hivld", 32'(bus.res_hi_vld), 32'h1);
    at_neg();
    check("t5b_ready", 32'(bus.req_ready), 32'h1);
    at_pos();
    drop(0);
    check("t5b_sum", bus.res_sum, 32'h0);
    check("t5b_cout", 32'(bus.res_cout), 32'h1);
    check("t5b_src", 32'(bus.res_lo_src), 32'h0);
`else
    check("t5_ready", 32'(bus.req_ready), 32'h8);
    at_pos();
    drop(3);
    check("t5_sum", bus.res_sum, 32'h8);
    check("t5_lo", 32'(bus.res_lo_src), 32'h3);
    check("t5_hivld", 32'(bus.res_hi_vld), 32'h0);
    at_neg();
    check("t5b_ready", 32'(bus.req_ready), 32'h1);
    at_pos();
    drop(0);
    check("t5b_sum", bus.res_sum, 32'h0);
    check("t5b_cout", 32'(bus.res_cout), 32'h1);
    at_neg();
    check("t5c_ready", 32'(bus.req_ready), 32'h2);
    at_pos();
    drop(1);
    check("t5c_sum", bus.res_sum, 32'h30);
    check("t5c_src", 32'(bus.res_lo_src), 32'h1);
`endif

    // 6: async reset with a result held
    at_neg();
    set_req(2, 1'b1, 32'h1, 32'h2, 4'h9);
    #1;
    check("t6_ready", 32'(bus.req_ready), 32'h4);
    at_pos();
    drop(2);
    check("t6_valid", 32'(bus.res_valid), 32'h1);
    check("t6_sum", bus.res_sum, 32'h3);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rvalid", 32'(bus.res_valid), 32'h0);
    check("t6_rsum", bus.res_sum, 32'h0);
    check("t6_rlovld", 32'(bus.res_lo_vld), 32'h0);
    check("t6_rwide", 32'(bus.res_wide), 32'h0);
    check("t6_rid", 32'(bus.res_lo_id), 32'h0);
    set_req(2, 1'b1, 32'h4, 32'h4, 4'h2);
    set_req(3, 1'b1, 32'h6, 32'h6, 4'h3);
    #1;
    check("t6_rready", 32'(bus.req_ready), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("t6_first", 32'(bus.req_ready), 32'h4);
    at_pos();
    check("t6_src", 32'(bus.res_lo_src), 32'h2);
    check("t6_sum2", bus.res_sum, 32'h8);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
